// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller: drives the digit mux select, captures
// the returned nibble after a blanking interval and lights one active-low anode per slot.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_mask,
  input  logic [3:0] dp_in,
  input  logic [3:0] mux_y,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       slot_tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_CAPT = CW'(BLANK_CYCLES - 1);

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    an_q,  an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q,  dp_d;
  logic          tick_q, tick_d;

  // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    an_d   = an_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    tick_d = 1'b0;
    if (!en) begin
      cnt_d = '0;
      sel_d = 2'd0;
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      // New slot: move the mux and blank while it settles.
      cnt_d  = '0;
      sel_d  = sel_q + 2'd1;
      an_d   = AN_OFF;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_CAPT) begin
        seg_d        = hex_to_seg(mux_y);
        dp_d         = ~dp_in[sel_q];
        an_d         = AN_OFF;
        an_d[sel_q]  = ~digit_mask[sel_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= 2'd0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign sel       = sel_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2 and a model
// 4:1 mux; expectations come from a slot-arithmetic reference model.
module tb_seg7_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] digit_mask;
  logic [3:0] dp_in;
  logic [3:0] mux_y;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       slot_tick;

  logic [3:0] digits [4];
  logic [6:0] dec_tab [16];

  // Expected {sel, an, seg, dp, slot_tick}, one entry per clock edge.
  logic [14:0] exp_q [$];

  int k;
  logic [1:0] m_sel;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;
  logic       m_tick;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mux_y = digits[sel];

  seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
    .dp_in      (dp_in),
    .mux_y      (mux_y),
    .sel        (sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .slot_tick  (slot_tick)
  );

  // k counts enabled edges since the scan last restarted; cnt = k%SD, slot = (k/SD)%4.
  task automatic tick();
    int pos;
    int slot;
    logic [3:0] onehot;
    @(posedge clk);
    if (!rst_n || !en) begin
      k = 0;
      m_sel = 2'd0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_tick = 1'b0;
    end else begin
      k++;
      pos  = k % SD;
      slot = (k / SD) % 4;
      m_sel  = 2'(slot);
      m_tick = (pos == 0);
      if (pos == 0) m_an = 4'hF;
      if (pos == BC) begin
        onehot = 4'b0001 << slot;
        m_seg  = dec_tab[digits[slot]];
        m_dp   = ~dp_in[slot];
        m_an   = digit_mask[slot] ? ~onehot : 4'hF;
      end
    end
    exp_q.push_back({m_sel, m_an, m_seg, m_dp, m_tick});
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] e;
    rst_n = 1'b0; en = 1'b1; digit_mask = 4'hF; dp_in = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({sel, an, seg, dp, slot_tick} !== {2'd0, 4'hF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_state: got %h required %h", {sel, an, seg, dp, slot_tick},
                 {2'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({sel, an, seg, dp, slot_tick} !== e) begin
        n_fail++;
        $display("FAIL reset_release: got %h required %h k=%0d", {sel, an, seg, dp, slot_tick}, e, k);
      end
    end
    n_cmp++;
    if (an !== 4'hE || seg !== 7'h79) begin
      n_fail++;
      $display("FAIL first_digit: got an=%h seg=%h required an=e seg=79", an, seg);
    end
  endtask

  task automatic test_full_scan();
    logic [14:0] e;
    logic [3:0]  prev_an;
    logic [6:0]  got_seg [$];
    int          tick_at [$];
    logic [6:0]  want_seg [4] = '{7'h79, 7'h24, 7'h08, 7'h0E};
    prev_an = an;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({sel, an, seg, dp, slot_tick} !== e) begin
        n_fail++;
        $display("FAIL full_scan: got %h required %h k=%0d", {sel, an, seg, dp, slot_tick}, e, k);
      end
      if (prev_an == 4'hF && an != 4'hF) got_seg.push_back(seg);
      if (slot_tick) tick_at.push_back(k);
      prev_an = an;
    end
    n_cmp++;
    if (got_seg.size() != 3 && got_seg.size() != 4) begin
      n_fail++;
      $display("FAIL scan_seg_count: got %0d required 3 or 4", got_seg.size());
    end
    // Scan starts mid slot 0 (already lit), so captures seen are slots 1,2,3 then 0.
    for (int i = 0; i < got_seg.size() && i < 4; i++) begin
      n_cmp++;
      if (got_seg[i] !== want_seg[(i + 1) % 4]) begin
        n_fail++;
        $display("FAIL scan_seg_seq[%0d]: got %h required %h", i, got_seg[i], want_seg[(i + 1) % 4]);
      end
    end
    n_cmp++;
    if (tick_at.size() != 4) begin
      n_fail++;
      $display("FAIL tick_count: got %0d required 4", tick_at.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (tick_at[i] != 8 * (i + 1)) begin
          n_fail++;
          $display("FAIL tick_cycle[%0d]: got %0d required %0d", i, tick_at[i], 8 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_mask_dp();
    logic [14:0] e;
    logic [3:0]  prev_an;
    int          guard;
    digit_mask = 4'b1010;
    dp_in      = 4'b0100;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({sel, an, seg, dp, slot_tick} !== e) begin
        n_fail++;
        $display("FAIL mask_dp: got %h required %h k=%0d", {sel, an, seg, dp, slot_tick}, e, k);
      end
      if (i >= 16) begin
        n_cmp++;
        if (an == 4'hE || an == 4'hB || (dp == 1'b0 && !(sel == 2'd2 || (sel == 2'd3 && an == 4'hF)))) begin
          n_fail++;
          $display("FAIL mask_visible: got an=%h dp=%b sel=%0d required digits 0/2 dark, dp only slot 2", an, dp, sel);
        end
      end
    end
    guard = 0;
    while ((k % SD) != 4 && guard < 16) begin
      tick();
      e = exp_q.pop_front();
      guard++;
    end
    prev_an = an;
    digit_mask = 4'b0101;
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (an !== prev_an || {sel, an, seg, dp, slot_tick} !== e) begin
      n_fail++;
      $display("FAIL mask_midslot: got an=%h required an=%h (full %h vs %h)", an, prev_an,
               {sel, an, seg, dp, slot_tick}, e);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({sel, an, seg, dp, slot_tick} !== e) begin
        n_fail++;
        $display("FAIL mask_next: got %h required %h k=%0d", {sel, an, seg, dp, slot_tick}, e, k);
      end
    end
    digit_mask = 4'hF;
    dp_in      = 4'h0;
  endtask

  task automatic test_en_drop();
    logic [14:0] e;
    int          guard;
    guard = 0;
    while ((k % 32) != 29 && guard < 40) begin
      tick();
      e = exp_q.pop_front();
      guard++;
    end
    en = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (an !== 4'hF || sel !== 2'd0 || seg !== 7'h7F || dp !== 1'b1 || slot_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop: got sel=%0d an=%h seg=%h dp=%b tick=%b required 0 f 7f 1 0", sel, an, seg, dp, slot_tick);
    end
    tick();
    e = exp_q.pop_front();
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({sel, an, seg, dp, slot_tick} !== e || slot_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL en_restart: got %h required %h k=%0d", {sel, an, seg, dp, slot_tick}, e, k);
      end
    end
    n_cmp++;
    if (an !== 4'hE) begin
      n_fail++;
      $display("FAIL en_relight: got an=%h required e", an);
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] e;
    int          guard;
    logic        saw_24;
    guard = 0;
    while ((k % 32) != 9 && guard < 40) begin
      tick();
      e = exp_q.pop_front();
      guard++;
    end
    rst_n = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if ({sel, an, seg, dp, slot_tick} !== {2'd0, 4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: got %h required %h", {sel, an, seg, dp, slot_tick}, {2'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    end
    saw_24 = (seg == 7'h24);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({sel, an, seg, dp, slot_tick} !== e) begin
        n_fail++;
        $display("FAIL reset_mid_after: got %h required %h k=%0d", {sel, an, seg, dp, slot_tick}, e, k);
      end
      if (seg == 7'h24) saw_24 = 1'b1;
    end
    n_cmp++;
    if (saw_24 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_partial: got seg=24 seen required never");
    end
  endtask

  task automatic test_decode();
    logic [14:0] e;
    logic [6:0]  want [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    en = 1'b0;
    tick();
    e = exp_q.pop_front();
    en = 1'b1;
    for (int v = 0; v < 16; v++) begin
      digits[0] = 4'(v);
      for (int i = 0; i < 32; i++) begin
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if ({sel, an, seg, dp, slot_tick} !== e) begin
          n_fail++;
          $display("FAIL decode_scan: got %h required %h k=%0d", {sel, an, seg, dp, slot_tick}, e, k);
        end
        if ((k % 32) == 4) begin
          n_cmp++;
          if (seg !== want[v] || an !== 4'hE) begin
            n_fail++;
            $display("FAIL decode_%h: got seg=%h an=%h required seg=%h an=e", v[3:0], seg, an, want[v]);
          end
        end
      end
    end
    digits[0] = 4'h1;
  endtask

  task automatic test_random();
    logic [14:0] e;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) digit_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) digits[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 39) != 0);
      rst_n = ($urandom_range(0, 79) != 0);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({sel, an, seg, dp, slot_tick} !== e) begin
        n_fail++;
        $display("FAIL random: got %h required %h k=%0d", {sel, an, seg, dp, slot_tick}, e, k);
      end
    end
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    digits[0] = 4'h1; digits[1] = 4'h2; digits[2] = 4'hA; digits[3] = 4'hF;
    rst_n = 1'b0; en = 1'b0; digit_mask = 4'hF; dp_in = 4'h0;
    k = 0;
    m_sel = 2'd0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_tick = 1'b0;

    test_reset();
    test_full_scan();
    test_mask_dp();
    test_en_drop();
    test_reset_mid();
    test_decode();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed 4-digit seven-segment scan controller that sits directly upstream and downstream of the 4-bit 4:1 digit mux. It drives the mux `sel` input from a prescaled slot counter and captures the mux output nibble. It decodes the nibble to active-low segments and drives one active-low anode per slot. A blanking interval at the start of each slot suppresses ghosting while `sel` and the mux output settle.

## Interface

- `SCAN_DIV`, default 100000: clock cycles per digit slot; legal range is ≥ 2.
- `BLANK_CYCLES`, default 1000: anodes-off cycles at the start of each slot; legal range is 1 ≤ BLANK_CYCLES < SCAN_DIV.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  scan enable; low blanks the display and holds the scan at slot 0.
- `digit_mask`  in  4  per-digit enable; bit i=1 lets digit i light.
- `dp_in`  in  4  per-digit decimal point, active-high; bit i belongs to digit i.
- `mux_y`  in  4  nibble returned by the 4:1 mux for the current `sel`.
- `sel`  out  2  digit select to the mux; registered.
- `an`  out  4  anodes, active-low, one-hot-low or all-high; registered.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low; registered.
- `dp`  out  1  decimal point, active-low; registered.
- `slot_tick`  out  1  one-cycle pulse on the cycle a new slot begins.

## Operation

- **Slot counter.** `cnt` counts 0 to SCAN_DIV-1 and wraps to 0. Its width is clog2(SCAN_DIV).
- **End of slot.** On the edge where `cnt`==SCAN_DIV-1 and `en`=1:
  - `cnt` goes to 0.
  - `sel` goes to `sel`+1 (mod 4, so 3→0).
  - `an` goes to 4'hF.
  - `slot_tick` goes to 1 for exactly one cycle.
- **Capture.** On the edge where `cnt`==BLANK_CYCLES-1 and `en`=1:
  - `seg` loads decode(`mux_y`).
  - `dp` loads ~`dp_in[sel]`.
  - `an` loads all 1s except bit `sel`, which is ~`digit_mask[sel]`.
- **Mask timing.** `digit_mask` and `dp_in` are sampled only at the capture edge. Changes mid-slot take effect in the next slot.
- **Masked digit.** The anode stays high. `seg` and `dp` still update.
- **Decode (hex, active-low, {g..a}):**
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03
  - C=46, d=21, E=06, F=0E
- **`en`=0.** On every edge, the block forces:
  - `cnt`=0, `sel`=0
  - `an`=F, `seg`=7F, `dp`=1
  - `slot_tick`=0
- **`en` returns to 1.** The scan restarts at slot 0 with a full blanking interval. No `slot_tick` is generated for this restart.
- **Reset.** `rst_n`=0 sampled on an edge gives the same state as `en`=0, and takes priority over `en`.
  - Reset values: `sel`=0, `an`=4'hF, `seg`=7'h7F, `dp`=1, `slot_tick`=0, `cnt`=0.
  - Reset mid-slot aborts the slot immediately. No partial capture occurs.
- **Precedence at one edge.** Reset beats `en`=0, which beats end of slot, which beats capture. Capture and end of slot can never coincide because BLANK_CYCLES < SCAN_DIV.

## Timing

- `sel` changes on the same edge that `an` goes all-high. The mux therefore has BLANK_CYCLES cycles to settle before capture.
- Per slot, anode timing is:
  - `an` is all-high for BLANK_CYCLES cycles (`cnt` = 0 to BLANK_CYCLES-1).
  - `an` is active for SCAN_DIV-BLANK_CYCLES cycles.
- Full refresh period is 4·SCAN_DIV cycles.
- Capture latency: `mux_y` sampled at the capture edge appears on `seg` one cycle later, coincident with the anode turning on.
- `slot_tick` is high during the cycle where `cnt`==0 for slots entered by wrap.
- Only one `an` bit is ever low. Anode-on periods for different digits never overlap or abut; they are separated by ≥ BLANK_CYCLES cycles.

## Test plan

Every scenario uses SCAN_DIV=8 and BLANK_CYCLES=2, with a model mux where d0=1, d1=2, d2=A, d3=F.

1. **Reset state.** Hold `rst_n`=0 for 3 cycles.
   - Required: `sel`=0, `an`=F, `seg`=7F, `dp`=1, `slot_tick`=0.
   - After release with `en`=1 and `digit_mask`=F: the first `an`=E appears at cycle 2, with `seg`=79.
2. **Full scan.** Run 32 cycles.
   - Required `an` sequence: E, D, B, 7, each low for 6 cycles, preceded by 2 cycles of F.
   - Required `seg` sequence: 79, 24, 08, 0E.
   - `slot_tick` pulses at cycles 8, 16, 24, 32.
3. **Mask and decimal point.** Set `digit_mask`=4'b1010 and `dp_in`=4'b0100.
   - Digits 0 and 2 stay with `an`=F.
   - `dp`=0 only during slot 2.
   - Flip the mask mid-slot: no change until the next capture.
4. **Enable drop.** Drop `en` in slot 3 at `cnt`=5.
   - Next edge: `an`=F, `sel`=0, `seg`=7F.
   - Re-raise `en`: digit 0 lights 2 cycles later, and no `slot_tick` fires.
5. **Reset mid-operation.** Assert `rst_n`=0 at `cnt`=1 of slot 1, before capture.
   - Next edge: all outputs are at reset values.
   - No `seg`=24 ever appears for that slot.
6. **Decode sweep.** Drive d0 through all values 0 to F over 16 full periods.
   - `seg` must match the full decode list in Operation.
